// File: rtl/de_port_arbiter.sv
// de_port_arbiter: round-robin arbiter sharing the drawing-engine memory port between ports A and B, with an optional burst lock
module de_port_arbiter #(
  parameter int ADDR_W    = 18,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_lock,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [3:0]        a_nbyte,
  input  logic              a_rnw,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_gnt,
  input  logic              b_req,
  input  logic              b_lock,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [3:0]        b_nbyte,
  input  logic              b_rnw,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_gnt,
  output logic              de_req,
  input  logic              de_ack,
  output logic [ADDR_W-1:0] de_addr,
  output logic [3:0]        de_nbyte,
  output logic              de_rnw,
  output logic [DATA_W-1:0] de_w_data,
  input  logic [DATA_W-1:0] de_r_data
);
  typedef enum logic [1:0] {ARB, GNT_A, GNT_B} state_t;
  localparam logic [3:0] MAX_B = 4'(MAX_BURST);
  state_t     state_q;
  logic       rr_last_q;
  logic [3:0] burst_cnt_q;
  logic [3:0] cnt_inc;
  logic       own_req;
  logic       own_lock;
  assign a_gnt     = state_q == GNT_A;
  assign b_gnt     = state_q == GNT_B;
  assign own_req   = b_gnt ? b_req : a_req;
  assign own_lock  = b_gnt ? b_lock : a_lock;
  assign cnt_inc   = (&burst_cnt_q) ? burst_cnt_q : burst_cnt_q + 4'd1;
  assign de_req    = (a_gnt | b_gnt) & own_req;
  assign de_addr   = b_gnt ? b_addr : a_addr;
  assign de_nbyte  = b_gnt ? b_nbyte : a_nbyte;
  assign de_rnw    = b_gnt ? b_rnw : a_rnw;
  assign de_w_data = b_gnt ? b_wdata : a_wdata;
  assign a_ack     = a_gnt & de_ack;
  assign b_ack     = b_gnt & de_ack;
  assign a_rdata   = a_gnt ? de_r_data : '0;
  assign b_rdata   = b_gnt ? de_r_data : '0;
  // Ownership FSM: rr_last_q=1 means B was served last, so A wins the next tie
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB;
      rr_last_q   <= 1'b1;
      burst_cnt_q <= '0;
    end else if (state_q == ARB) begin
      burst_cnt_q <= '0;
      if (a_req && (!b_req || rr_last_q)) state_q <= GNT_A;
      else if (b_req) state_q <= GNT_B;
    end else if (de_ack) begin
      burst_cnt_q <= cnt_inc;
      rr_last_q   <= b_gnt;
      if (!(own_lock && cnt_inc < MAX_B)) state_q <= ARB;
    end else if (!own_req && !own_lock) begin
      state_q <= ARB;
    end
  end
endmodule
